msrv32_dmem_ahb_master: RTL and testbench
=========================================

Name: msrv32_dmem_ahb_master

Overview:
- Data-memory bus master directly downstream of the store unit.
- Converts the core's word-aligned data-memory request into single AHB-Lite transfers: store request with byte-lane mask, or load request.
- Sequences the address and data phases and honours HREADY wait states and two-cycle HRESP errors.
- Returns load data and a stall/done handshake to the pipeline.
- Only one transfer is outstanding; no bursts.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, bus data width; fixed at 32, four byte lanes.

Ports:
ms_riscv32_mp_clk_in  input  1  core clock; all state changes on the rising edge
ms_riscv32_mp_rst_in  input  1  asynchronous, active-high reset
dmaddr_in  input  32  word-aligned address from the store unit; bits [1:0] are always 0
dmdata_in  input  32  lane-positioned write data
dmwr_mask_in  input  4  byte-lane write mask
dmwr_req_in  input  1  store request
dmrd_req_in  input  1  load request; if both requests are high, store wins
rd_size_in  input  2  load size: 00 byte, 01 half, 10 word
rd_offset_in  input  2  load byte offset
hready_in  input  1  AHB HREADY
hresp_in  input  1  AHB HRESP; 1 = ERROR
hrdata_in  input  32  AHB HRDATA
haddr_out  output  32  AHB HADDR
htrans_out  output  2  AHB HTRANS; 00 IDLE, 10 NONSEQ
hwrite_out  output  1  AHB HWRITE
hsize_out  output  3  AHB HSIZE
hwdata_out  output  32  AHB HWDATA
busy_out  output  1  pipeline stall
done_out  output  1  one-cycle pulse when a transfer completes
rdata_out  output  32  raw load word, valid while done_out=1 for a load
bus_err_out  output  1  one-cycle pulse coincident with done_out on an ERROR response

Behaviour:
- Reset, asynchronous: state=IDLE; haddr_out=0, htrans_out=00, hwrite_out=0, hsize_out=010, hwdata_out=0, busy_out=0, done_out=0, rdata_out=0, bus_err_out=0.
- FSM states: IDLE, ADDR, DATA, ERR2. All outputs are registered.
- IDLE:
  - Request present (dmwr_req_in or dmrd_req_in) → capture the request, go to ADDR, busy_out=1 from the next cycle.
  - Store decode from the mask, setting haddr_out[1:0] and hsize_out:
    - 0001→00/byte, 0010→01/byte, 0100→10/byte, 1000→11/byte
    - 0011→00/half, 1100→10/half
    - 1111→00/word
    - Any other non-zero mask → word at offset 00.
    - Mask 0000 with dmwr_req_in=1 → request ignored; stay IDLE.
  - Load: haddr_out={dmaddr_in[31:2], rd_offset_in}, hsize_out={1'b0, rd_size_in}.
- ADDR:
  - htrans_out=10, hwrite_out = (store).
  - Hold haddr_out, hsize_out and hwrite_out while hready_in=0.
  - On hready_in=1 → go to DATA; htrans_out=00 next cycle; for a store, hwdata_out=captured dmdata_in from the next cycle.
- DATA:
  - hwdata_out is held stable until completion.
  - hready_in=1 & hresp_in=0 → done_out=1 next cycle, rdata_out=hrdata_in (loads only; stores leave rdata_out unchanged), go to IDLE, busy_out=0.
  - hready_in=0 & hresp_in=1 → go to ERR2.
  - hready_in=0 & hresp_in=0 → wait, unbounded.
- ERR2: wait for hready_in=1 (with hresp_in=1), then pulse done_out=1 and bus_err_out=1, rdata_out unchanged, go to IDLE.
- Requests arriving while busy_out=1 are ignored. The pipeline must hold a request until done_out.
- A new request may be accepted in the same cycle done_out pulses; the requester must deassert its request on done_out.
- Throughput and latency: minimum three cycles from request to done_out (accept, ADDR, DATA); each wait state adds one.
- Reset asserted mid-transfer forces IDLE immediately with htrans_out=00. The bus slave is assumed reset by the same signal.
- haddr_out, hwrite_out and hsize_out hold their last values in IDLE; htrans_out=00 makes them don't-care.

Test Plan:
- Word store, addr 0x0000_1000, mask 1111, data 0xDEADBEEF, hready always 1 → ADDR cycle haddr=0x1000, hsize=010, hwrite=1, htrans=10; DATA cycle hwdata=0xDEADBEEF; done_out on cycle 3; bus_err_out=0.
- Byte store, addr 0x0000_2000, mask 0100, data 0x00AB0000 → haddr=0x2002, hsize=000, hwdata=0x00AB0000.
- Halfword load, offset 10, addr 0x3000, two DATA wait states, hrdata=0x12345678 → done_out 5 cycles after request, rdata_out=0x12345678, busy_out high for 4 cycles.
- ERROR response in DATA (hready=0/hresp=1, then hready=1/hresp=1) → done_out and bus_err_out pulse together; return to IDLE.
- Reset asserted during DATA with hready=0 → htrans_out=00, busy_out=0 immediately; subsequent word load completes normally.
- Store and load requested together, then mask 0000 store alone → store executed (hwrite=1); zero-mask request produces no bus transfer and busy_out stays 0.

Source files
------------

// File: rtl/msrv32_dmem_ahb_master.sv
// ---------------------------------------------------------------------------
// msrv32_dmem_ahb_master
//
// Data-memory bus master sitting behind the store unit. It turns one
// word-aligned core request (a store with a byte-lane mask, or a load) into a
// single AHB-Lite transfer. It sequences the address and data phases, honours
// HREADY wait states and the two-cycle HRESP ERROR response, and hands the
// pipeline a busy/done handshake plus the raw load word. Only one transfer is
// ever outstanding and bursts are never issued.
//
// Ports
//   ms_riscv32_mp_clk_in  in   core clock, rising edge
//   ms_riscv32_mp_rst_in  in   asynchronous active-high reset
//   dmaddr_in             in   word-aligned request address
//   dmdata_in             in   lane-positioned store data
//   dmwr_mask_in          in   store byte-lane mask
//   dmwr_req_in           in   store request (wins over a load)
//   dmrd_req_in           in   load request
//   rd_size_in            in   load size 00 byte / 01 half / 10 word
//   rd_offset_in          in   load byte offset within the word
//   hready_in             in   AHB HREADY
//   hresp_in              in   AHB HRESP, 1 = ERROR
//   hrdata_in             in   AHB HRDATA
//   haddr_out             out  AHB HADDR
//   htrans_out            out  AHB HTRANS (IDLE / NONSEQ only)
//   hwrite_out            out  AHB HWRITE
//   hsize_out             out  AHB HSIZE
//   hwdata_out            out  AHB HWDATA
//   busy_out              out  pipeline stall while a transfer is in flight
//   done_out              out  one-cycle completion pulse
//   rdata_out             out  raw load word, valid with done_out on a load
//   bus_err_out           out  one-cycle pulse with done_out on ERROR
// ---------------------------------------------------------------------------
module msrv32_dmem_ahb_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              ms_riscv32_mp_clk_in,
    input  logic              ms_riscv32_mp_rst_in,
    input  logic [ADDR_W-1:0] dmaddr_in,
    input  logic [DATA_W-1:0] dmdata_in,
    input  logic [3:0]        dmwr_mask_in,
    input  logic              dmwr_req_in,
    input  logic              dmrd_req_in,
    input  logic [1:0]        rd_size_in,
    input  logic [1:0]        rd_offset_in,
    input  logic              hready_in,
    input  logic              hresp_in,
    input  logic [DATA_W-1:0] hrdata_in,
    output logic [ADDR_W-1:0] haddr_out,
    output logic [1:0]        htrans_out,
    output logic              hwrite_out,
    output logic [2:0]        hsize_out,
    output logic [DATA_W-1:0] hwdata_out,
    output logic              busy_out,
    output logic              done_out,
    output logic [DATA_W-1:0] rdata_out,
    output logic              bus_err_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_ERR2 = 2'd3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Store mask -> {byte offset, HSIZE}. Masks that do not describe a
    // naturally aligned byte/half/word are issued as a full word at offset 0.
    function automatic logic [4:0] store_decode(input logic [3:0] mask);
        case (mask)
            4'b0001: store_decode = {2'b00, HSIZE_BYTE};
            4'b0010: store_decode = {2'b01, HSIZE_BYTE};
            4'b0100: store_decode = {2'b10, HSIZE_BYTE};
            4'b1000: store_decode = {2'b11, HSIZE_BYTE};
            4'b0011: store_decode = {2'b00, HSIZE_HALF};
            4'b1100: store_decode = {2'b10, HSIZE_HALF};
            default: store_decode = {2'b00, HSIZE_WORD};
        endcase
    endfunction

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_haddr;
    logic [1:0]        r_htrans;
    logic              r_hwrite;
    logic [2:0]        r_hsize;
    logic [DATA_W-1:0] r_hwdata;
    logic [DATA_W-1:0] r_wdata;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic       w_st_go;
    logic       w_ld_go;
    logic [4:0] w_st_dec;
    logic       w_unused;

    // A store with an empty mask has nothing to write and is dropped; store
    // otherwise takes priority over a simultaneous load.
    assign w_st_go  = dmwr_req_in && (dmwr_mask_in != 4'b0000);
    assign w_ld_go  = dmrd_req_in && !w_st_go;
    assign w_st_dec = store_decode(dmwr_mask_in);
    // Request addresses are word aligned; the low bits are always zero.
    assign w_unused = ^dmaddr_in[1:0];

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_state  <= S_IDLE;
            r_haddr  <= '0;
            r_htrans <= HTRANS_IDLE;
            r_hwrite <= 1'b0;
            r_hsize  <= HSIZE_WORD;
            r_hwdata <= '0;
            r_wdata  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_st_go) begin
                        r_state  <= S_ADDR;
                        r_busy   <= 1'b1;
                        r_htrans <= HTRANS_NONSEQ;
                        r_hwrite <= 1'b1;
                        r_haddr  <= {dmaddr_in[ADDR_W-1:2], w_st_dec[4:3]};
                        r_hsize  <= w_st_dec[2:0];
                        r_wdata  <= dmdata_in;
                    end else if (w_ld_go) begin
                        r_state  <= S_ADDR;
                        r_busy   <= 1'b1;
                        r_htrans <= HTRANS_NONSEQ;
                        r_hwrite <= 1'b0;
                        r_haddr  <= {dmaddr_in[ADDR_W-1:2], rd_offset_in};
                        r_hsize  <= {1'b0, rd_size_in};
                    end
                end
                S_ADDR: begin
                    // Address phase ends when the slave signals HREADY.
                    if (hready_in) begin
                        r_state  <= S_DATA;
                        r_htrans <= HTRANS_IDLE;
                        if (r_hwrite) begin
                            r_hwdata <= r_wdata;
                        end
                    end
                end
                S_DATA: begin
                    if (hready_in) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        if (hresp_in) begin
                            r_err <= 1'b1;
                        end else if (!r_hwrite) begin
                            r_rdata <= hrdata_in;
                        end
                    end else if (hresp_in) begin
                        // First cycle of a two-cycle ERROR response.
                        r_state <= S_ERR2;
                    end
                end
                S_ERR2: begin
                    if (hready_in) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign haddr_out   = r_haddr;
    assign htrans_out  = r_htrans;
    assign hwrite_out  = r_hwrite;
    assign hsize_out   = r_hsize;
    assign hwdata_out  = r_hwdata;
    assign busy_out    = r_busy;
    assign done_out    = r_done;
    assign rdata_out   = r_rdata;
    assign bus_err_out = r_err;

endmodule

// File: tb/tb_msrv32_dmem_ahb_master.sv
module tb_msrv32_dmem_ahb_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] dmaddr_in = '0;
    logic [31:0] dmdata_in = '0;
    logic [3:0]  dmwr_mask_in = '0;
    logic        dmwr_req_in = 1'b0;
    logic        dmrd_req_in = 1'b0;
    logic [1:0]  rd_size_in = '0;
    logic [1:0]  rd_offset_in = '0;
    logic        hready_in = 1'b1;
    logic        hresp_in = 1'b0;
    logic [31:0] hrdata_in = '0;
    logic [31:0] haddr_out;
    logic [1:0]  htrans_out;
    logic        hwrite_out;
    logic [2:0]  hsize_out;
    logic [31:0] hwdata_out;
    logic        busy_out;
    logic        done_out;
    logic [31:0] rdata_out;
    logic        bus_err_out;

    always #5 clk = ~clk;

    msrv32_dmem_ahb_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .ms_riscv32_mp_clk_in(clk),
        .ms_riscv32_mp_rst_in(rst),
        .dmaddr_in(dmaddr_in),
        .dmdata_in(dmdata_in),
        .dmwr_mask_in(dmwr_mask_in),
        .dmwr_req_in(dmwr_req_in),
        .dmrd_req_in(dmrd_req_in),
        .rd_size_in(rd_size_in),
        .rd_offset_in(rd_offset_in),
        .hready_in(hready_in),
        .hresp_in(hresp_in),
        .hrdata_in(hrdata_in),
        .haddr_out(haddr_out),
        .htrans_out(htrans_out),
        .hwrite_out(hwrite_out),
        .hsize_out(hsize_out),
        .hwdata_out(hwdata_out),
        .busy_out(busy_out),
        .done_out(done_out),
        .rdata_out(rdata_out),
        .bus_err_out(bus_err_out)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Expected bus/pipeline view for the current cycle.
    logic [31:0] e_haddr, e_hwdata, e_rdata;
    logic [1:0]  e_htrans;
    logic [2:0]  e_hsize;
    logic        e_hwrite, e_busy, e_done, e_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("haddr",  haddr_out, e_haddr);
            check("htrans", 32'(htrans_out), 32'(e_htrans));
            check("hwrite", 32'(hwrite_out), 32'(e_hwrite));
            check("hsize",  32'(hsize_out), 32'(e_hsize));
            check("hwdata", hwdata_out, e_hwdata);
            check("busy",   32'(busy_out), 32'(e_busy));
            check("done",   32'(done_out), 32'(e_done));
            check("rdata",  rdata_out, e_rdata);
            check("bus_err", 32'(bus_err_out), 32'(e_err));
        end
    end

    task automatic model_reset();
        e_haddr = '0; e_htrans = 2'b00; e_hwrite = 1'b0; e_hsize = 3'b010;
        e_hwdata = '0; e_busy = 1'b0; e_done = 1'b0; e_rdata = '0; e_err = 1'b0;
    endtask

    // A mask that is a run of 1, 2 or 4 lanes aligned to its own size maps to
    // byte/half/word at its lowest lane; anything else is a word at offset 0.
    task automatic mask_to_bus(input logic [3:0] m, output logic [1:0] off, output logic [2:0] sz);
        int cnt;
        int lo;
        int run;
        cnt = $countones(m);
        lo  = 0;
        for (int i = 3; i >= 0; i--) if (m[i]) lo = i;
        run = ((1 << cnt) - 1) << lo;
        if ((cnt == 1 || cnt == 2 || cnt == 4) && (lo % cnt == 0) && (run == int'(m))) begin
            off = 2'(lo);
            sz  = (cnt == 1) ? 3'd0 : (cnt == 2) ? 3'd1 : 3'd2;
        end else begin
            off = 2'd0;
            sz  = 3'd2;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request held until completion. aw/dw are ADDR/DATA wait states;
    // err answers the data phase with a two-cycle ERROR. Returns a few DUT
    // observations for literal checks by the caller.
    task automatic run_xfer(input bit st, input bit ld, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] mask,
                            input logic [1:0] rsz, input logic [1:0] roff,
                            input int aw, input int dw, input bit err,
                            input logic [31:0] rdat,
                            output int done_cyc, output int busy_cnt,
                            output logic [31:0] c_haddr, output logic [2:0] c_hsize,
                            output logic c_hwrite, output logic [31:0] c_hwdata,
                            output logic c_err);
        bit          is_st;
        logic [1:0]  off;
        logic [2:0]  sz;
        logic [31:0] m_addr;
        int          cyc;
        is_st = st && (mask != 4'b0000);
        done_cyc = -1; busy_cnt = 0; cyc = 0;
        c_haddr = 'x; c_hsize = 'x; c_hwrite = 1'bx; c_hwdata = 'x; c_err = 1'bx;
        tick();
        dmwr_req_in = st; dmrd_req_in = ld; dmaddr_in = addr; dmdata_in = data;
        dmwr_mask_in = mask; rd_size_in = rsz; rd_offset_in = roff;
        hready_in = 1'b1; hresp_in = 1'b0;
        e_done = 1'b0; e_err = 1'b0; e_busy = 1'b0; e_htrans = 2'b00;
        if (!is_st && !ld) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                busy_cnt += int'(busy_out);
            end
            dmwr_req_in = 1'b0; dmrd_req_in = 1'b0;
            return;
        end
        if (is_st) begin
            mask_to_bus(mask, off, sz);
        end else begin
            off = roff;
            sz  = {1'b0, rsz};
        end
        m_addr = {addr[31:2], off};
        for (int i = 0; i <= aw; i++) begin
            tick(); cyc++;
            busy_cnt += int'(busy_out);
            if (i == 0) begin
                c_haddr = haddr_out; c_hsize = hsize_out; c_hwrite = hwrite_out;
            end
            hready_in = (i == aw);
            e_htrans = 2'b10; e_busy = 1'b1; e_haddr = m_addr; e_hsize = sz; e_hwrite = is_st;
        end
        tick(); cyc++;
        busy_cnt += int'(busy_out);
        c_hwdata = hwdata_out;
        e_htrans = 2'b00;
        if (is_st) e_hwdata = data;
        if (err) begin
            hready_in = 1'b0; hresp_in = 1'b1; hrdata_in = 32'hBAD0_0000;
            tick(); cyc++;
            busy_cnt += int'(busy_out);
            hready_in = 1'b1; hresp_in = 1'b1;
        end else begin
            for (int j = 0; j <= dw; j++) begin
                if (j > 0) begin
                    tick(); cyc++;
                    busy_cnt += int'(busy_out);
                end
                hready_in = (j == dw); hresp_in = 1'b0;
                hrdata_in = (j == dw) ? rdat : (32'hBAD0_0000 + 32'(j));
            end
        end
        tick(); cyc++;
        busy_cnt += int'(busy_out);
        if (done_out) done_cyc = cyc;
        c_err = bus_err_out;
        dmwr_req_in = 1'b0; dmrd_req_in = 1'b0;
        hready_in = 1'b1; hresp_in = 1'b0;
        e_done = 1'b1; e_err = err; e_busy = 1'b0;
        if (!err && !is_st) e_rdata = rdat;
    endtask

    int          dc, bc;
    logic [31:0] ca, cw;
    logic [2:0]  cs;
    logic        cwr, ce;

    initial begin
        model_reset();
        #1 rst = 1'b1;
        chk_en = 1'b1;
        tick(); tick();
        check("reset_hsize", 32'(hsize_out), 32'h2);
        check("reset_busy", 32'(busy_out), 32'h0);
        rst = 1'b0;

        // Word store, no waits.
        run_xfer(1, 0, 32'h0000_1000, 32'hDEADBEEF, 4'b1111, 2'b00, 2'b00, 0, 0, 0, 32'h0,
                 dc, bc, ca, cs, cwr, cw, ce);
        check("t1_haddr", ca, 32'h0000_1000);
        check("t1_hsize", 32'(cs), 32'h2);
        check("t1_hwrite", 32'(cwr), 32'h1);
        check("t1_hwdata", cw, 32'hDEADBEEF);
        check("t1_done_cycle", 32'(dc), 32'd3);
        check("t1_bus_err", 32'(ce), 32'h0);

        // Byte store to lane 2.
        run_xfer(1, 0, 32'h0000_2000, 32'h00AB0000, 4'b0100, 2'b00, 2'b00, 0, 0, 0, 32'h0,
                 dc, bc, ca, cs, cwr, cw, ce);
        check("t2_haddr", ca, 32'h0000_2002);
        check("t2_hsize", 32'(cs), 32'h0);
        check("t2_hwdata", cw, 32'h00AB0000);

        // Upper-half store with one address-phase wait state.
        run_xfer(1, 0, 32'h0000_2100, 32'h5A5A0000, 4'b1100, 2'b00, 2'b00, 1, 0, 0, 32'h0,
                 dc, bc, ca, cs, cwr, cw, ce);
        check("t2b_haddr", ca, 32'h0000_2102);
        check("t2b_hsize", 32'(cs), 32'h1);
        check("t2b_done_cycle", 32'(dc), 32'd4);

        // Irregular mask falls back to a word at offset 0.
        run_xfer(1, 0, 32'h0000_2200, 32'h11223344, 4'b0101, 2'b00, 2'b00, 0, 0, 0, 32'h0,
                 dc, bc, ca, cs, cwr, cw, ce);
        check("t2c_haddr", ca, 32'h0000_2200);
        check("t2c_hsize", 32'(cs), 32'h2);

        // Halfword load, offset 2, two data wait states.
        run_xfer(0, 1, 32'h0000_3000, 32'hFFFF_FFFF, 4'b0000, 2'b01, 2'b10, 0, 2, 0, 32'h12345678,
                 dc, bc, ca, cs, cwr, cw, ce);
        check("t3_haddr", ca, 32'h0000_3002);
        check("t3_hsize", 32'(cs), 32'h1);
        check("t3_hwrite", 32'(cwr), 32'h0);
        check("t3_done_cycle", 32'(dc), 32'd5);
        check("t3_busy_cycles", 32'(bc), 32'd4);
        check("t3_rdata", rdata_out, 32'h12345678);

        // Load answered with an ERROR response.
        run_xfer(0, 1, 32'h0000_5000, 32'h0, 4'b0000, 2'b10, 2'b00, 0, 0, 1, 32'h0,
                 dc, bc, ca, cs, cwr, cw, ce);
        check("t4_done_cycle", 32'(dc), 32'd4);
        check("t4_bus_err", 32'(ce), 32'h1);
        check("t4_rdata_kept", rdata_out, 32'h12345678);

        // Reset asserted in the data phase while the slave stalls.
        tick();
        dmrd_req_in = 1'b1; dmaddr_in = 32'h0000_4000; rd_size_in = 2'b10; rd_offset_in = 2'b00;
        hready_in = 1'b1;
        e_done = 1'b0; e_err = 1'b0;
        tick();
        e_htrans = 2'b10; e_busy = 1'b1; e_haddr = 32'h0000_4000; e_hsize = 3'b010; e_hwrite = 1'b0;
        tick();
        hready_in = 1'b0;
        e_htrans = 2'b00;
        #1 rst = 1'b1;
        model_reset();
        dmrd_req_in = 1'b0;
        #1;
        check("t5_htrans_rst", 32'(htrans_out), 32'h0);
        check("t5_busy_rst", 32'(busy_out), 32'h0);
        tick();
        rst = 1'b0; hready_in = 1'b1;
        run_xfer(0, 1, 32'h0000_4000, 32'h0, 4'b0000, 2'b10, 2'b00, 0, 0, 0, 32'hCAFEF00D,
                 dc, bc, ca, cs, cwr, cw, ce);
        check("t5_done_cycle", 32'(dc), 32'd3);
        check("t5_rdata", rdata_out, 32'hCAFEF00D);

        // Store and load together: store wins.
        run_xfer(1, 1, 32'h0000_6000, 32'h0BADF00D, 4'b1111, 2'b10, 2'b00, 0, 0, 0, 32'h0,
                 dc, bc, ca, cs, cwr, cw, ce);
        check("t6_hwrite", 32'(cwr), 32'h1);
        check("t6_hwdata", cw, 32'h0BADF00D);

        // Zero-mask store alone is ignored.
        run_xfer(1, 0, 32'h0000_7000, 32'h77777777, 4'b0000, 2'b00, 2'b00, 0, 0, 0, 32'h0,
                 dc, bc, ca, cs, cwr, cw, ce);
        check("t6_zero_busy", 32'(bc), 32'h0);
        check("t6_zero_done", 32'(dc + 1), 32'h0);

        tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
